// File: rtl/phasecalc_ctrl.sv
// Sample-pair sequencer for the iterative phasecalc core: buffers (x, y) pairs,
// issues them through the start/busy handshake and strobes each finished angle.
module phasecalc_ctrl #(
    parameter int unsigned INSIZE    = 13,
    parameter int unsigned OUTSIZE   = 19,
    parameter int unsigned FIFODEPTH = 4,
    parameter int unsigned ACKWAIT   = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSIZE-1:0]  x_in,
    input  logic [INSIZE-1:0]  y_in,
    output logic               out_valid,
    output logic [OUTSIZE-1:0] angle_out,
    output logic [7:0]         overrun_cnt,
    output logic               ack_err,
    output logic               pc_start,
    input  logic               pc_busy,
    output logic [INSIZE-1:0]  pc_x,
    output logic [INSIZE-1:0]  pc_y,
    input  logic [OUTSIZE-1:0] pc_angle
);

    localparam int unsigned AW = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFODEPTH + 1);
    localparam int unsigned TW = $clog2(ACKWAIT + 1);
    localparam logic [CW-1:0] FULL    = CW'(FIFODEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(ACKWAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_count;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [TW-1:0]      r_to_cnt;
    logic [INSIZE-1:0]  r_mem_x [FIFODEPTH];
    logic [INSIZE-1:0]  r_mem_y [FIFODEPTH];
    logic               w_full;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic               w_capture;
    logic               w_timeout;

    assign w_full   = (r_count == FULL);
    assign in_ready = reset && !w_full;
    assign w_push   = in_valid && in_ready;
    // A pop in the same cycle never frees space for a push against a full FIFO.
    assign w_drop   = in_valid && w_full;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != CW'(0)) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_ARM;
            S_ARM: begin
                if (pc_busy) begin
                    w_state_nxt = S_RUN;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (!pc_busy) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_x[r_wr_ptr] <= x_in;
            r_mem_y[r_wr_ptr] <= y_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_to_cnt    <= '0;
            overrun_cnt <= '0;
            ack_err     <= 1'b0;
            pc_start    <= 1'b0;
            out_valid   <= 1'b0;
            pc_x        <= '0;
            pc_y        <= '0;
            angle_out   <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                pc_x     <= r_mem_x[r_rd_ptr];
                pc_y     <= r_mem_y[r_rd_ptr];
            end
            if (w_drop && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
            if (r_state == S_ISSUE) begin
                r_to_cnt <= '0;
            end else if ((r_state == S_ARM) && !pc_busy) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
            if (w_timeout) begin
                ack_err <= 1'b1;
            end
            if (w_capture) begin
                angle_out <= pc_angle;
            end
            pc_start  <= (w_state_nxt == S_ISSUE);
            out_valid <= (w_state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_phasecalc_ctrl.sv
// Self-checking bench for phasecalc_ctrl: transaction-level reference model
// plus a behavioural phasecalc core with programmable busy length.
module tb_phasecalc_ctrl;

    localparam int unsigned INSIZE  = 13;
    localparam int unsigned OUTSIZE = 19;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ACKW    = 3;

    logic               clock    = 1'b0;
    logic               reset    = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [INSIZE-1:0]  x_in     = '0;
    logic [INSIZE-1:0]  y_in     = '0;
    logic               out_valid;
    logic [OUTSIZE-1:0] angle_out;
    logic [7:0]         overrun_cnt;
    logic               ack_err;
    logic               pc_start;
    logic               pc_busy  = 1'b0;
    logic [INSIZE-1:0]  pc_x;
    logic [INSIZE-1:0]  pc_y;
    logic [OUTSIZE-1:0] pc_angle;

    phasecalc_ctrl #(
        .INSIZE   (INSIZE),
        .OUTSIZE  (OUTSIZE),
        .FIFODEPTH(DEPTH),
        .ACKWAIT  (ACKW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x_in       (x_in),
        .y_in       (y_in),
        .out_valid  (out_valid),
        .angle_out  (angle_out),
        .overrun_cnt(overrun_cnt),
        .ack_err    (ack_err),
        .pc_start   (pc_start),
        .pc_busy    (pc_busy),
        .pc_x       (pc_x),
        .pc_y       (pc_y),
        .pc_angle   (pc_angle)
    );

    always #5 clock = ~clock;

    function automatic logic [OUTSIZE-1:0] angle_of(input logic [INSIZE-1:0] x,
                                                    input logic [INSIZE-1:0] y);
        logic [31:0] p;
        p = 32'(x) * 32'(y);
        return p[OUTSIZE-1:0] ^ OUTSIZE'(y);
    endfunction

    assign pc_angle = angle_of(pc_x, pc_y);

    // Core model: busy rises after a start pulse and stays high busy_len cycles.
    int busy_len  = 4;
    bit never_ack = 1'b0;
    int rem       = 0;

    always @(negedge clock) begin
        if (!reset) begin
            rem     <= 0;
            pc_busy <= 1'b0;
        end else if (pc_start && !never_ack) begin
            rem     <= busy_len;
            pc_busy <= 1'b1;
        end else if (rem > 0) begin
            rem     <= rem - 1;
            pc_busy <= (rem > 1);
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: FIFO contents as queues, controller as idle/flight/done.
    logic [INSIZE-1:0]  qx[$];
    logic [INSIZE-1:0]  qy[$];
    int                 occ     = 0;
    int                 ph      = 0;
    int                 k       = 0;
    bit                 saw     = 1'b0;
    bit                 txn_na  = 1'b0;
    int                 e_ovr   = 0;
    bit                 e_ack   = 1'b0;
    bit                 e_start = 1'b0;
    bit                 e_ov    = 1'b0;
    logic [INSIZE-1:0]  e_px    = '0;
    logic [INSIZE-1:0]  e_py    = '0;
    logic [OUTSIZE-1:0] e_ang   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    task automatic step();
        bit v, rs, b, start_now, acc;
        logic [INSIZE-1:0] sx, sy;
        @(posedge clock);
        v  = in_valid;
        rs = reset;
        b  = pc_busy;
        sx = x_in;
        sy = y_in;
        #1;
        e_start = 1'b0;
        e_ov    = 1'b0;
        if (!rs) begin
            qx.delete();
            qy.delete();
            occ   = 0;
            ph    = 0;
            e_ovr = 0;
            e_ack = 1'b0;
            e_px  = '0;
            e_py  = '0;
            e_ang = '0;
        end else begin
            start_now = (ph == 0) && (occ > 0);
            acc       = v && (occ < int'(DEPTH));
            if (v && !acc && e_ovr < 255) e_ovr++;
            case (ph)
                0: if (start_now) begin
                    e_px    = qx.pop_front();
                    e_py    = qy.pop_front();
                    e_start = 1'b1;
                    txn_na  = never_ack;
                    saw     = 1'b0;
                    k       = -1;
                    ph      = 1;
                end
                1: begin
                    k++;
                    if (txn_na) begin
                        if (k == int'(ACKW)) begin
                            e_ack = 1'b1;
                            ph    = 0;
                        end
                    end else if (k >= 1 && b) begin
                        saw = 1'b1;
                    end else if (k >= 2 && saw && !b) begin
                        e_ov  = 1'b1;
                        e_ang = angle_of(e_px, e_py);
                        ph    = 2;
                    end
                end
                default: ph = 0;
            endcase
            if (acc) begin
                qx.push_back(sx);
                qy.push_back(sy);
            end
            occ = occ + int'(acc) - int'(start_now);
        end
        chk("in_ready",    32'(in_ready),    32'(reset && (occ < int'(DEPTH))));
        chk("pc_start",    32'(pc_start),    32'(e_start));
        chk("pc_x",        32'(pc_x),        32'(e_px));
        chk("pc_y",        32'(pc_y),        32'(e_py));
        chk("out_valid",   32'(out_valid),   32'(e_ov));
        chk("angle_out",   32'(angle_out),   32'(e_ang));
        chk("overrun_cnt", 32'(overrun_cnt), 32'(e_ovr));
        chk("ack_err",     32'(ack_err),     32'(e_ack));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            x_in     = INSIZE'($urandom);
            y_in     = INSIZE'($urandom);
            step();
        end
    endtask

    task automatic push(input logic [INSIZE-1:0] x, input logic [INSIZE-1:0] y);
        in_valid = 1'b1;
        x_in     = x;
        y_in     = y;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) step();
        reset = 1'b1;
    endtask

    initial begin
        do_reset(2);
        idle(2);

        // Single sample: zero angle, long busy.
        busy_len = 18;
        push(13'h0100, 13'h0000);
        idle(30);

        // Burst of six into a depth-4 FIFO while the core works on the first.
        busy_len = 12;
        for (int i = 0; i < 6; i++) push(INSIZE'($urandom), INSIZE'($urandom));
        idle(110);

        // Core that never acknowledges: two timeouts, no strobes.
        never_ack = 1'b1;
        push(13'h0123, 13'h0456);
        push(13'h1abc, 13'h0def);
        idle(20);
        never_ack = 1'b0;

        // Reset while RUN with two samples still queued.
        busy_len = 20;
        for (int i = 0; i < 3; i++) push(INSIZE'($urandom), INSIZE'($urandom));
        idle(6);
        do_reset(1);
        idle(30);
        busy_len = 3;
        push(13'h1fff, 13'h1000);
        idle(12);

        // Random traffic with varying busy lengths.
        for (int i = 0; i < 400; i++) begin
            busy_len = $urandom_range(2, 7);
            in_valid = ($urandom_range(0, 2) == 0);
            x_in     = INSIZE'($urandom);
            y_in     = INSIZE'($urandom);
            step();
        end
        idle(60);

        // Hold the FIFO full long enough to saturate the drop counter.
        do_reset(1);
        busy_len = 1000;
        for (int i = 0; i < 310; i++) begin
            in_valid = 1'b1;
            x_in     = INSIZE'($urandom);
            y_in     = INSIZE'($urandom);
            step();
        end
        in_valid = 1'b0;
        chk("overrun_sat", 32'(overrun_cnt), 32'd255);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
